pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Control side of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
//  Drives their hold (WEN, 1 = hold) and kill (forces the stage valid low) inputs.
//  Detects load-use hazards, flushes on taken branch/jump, and freezes on a multi-cycle data-memory wait.
//  Freezes the whole pipe when a halt retires. Keeps saturating stall and flush counters.
// PARAMETERS
//  CNT_W        16   width of stall_cnt and flush_cnt
//  MEM_TIMEOUT  64   max MEM_WAIT cycles before mem_err; range 1..2^CNT_W-1
// PORTS
//  CLK          in   1      clock; state updates on posedge, outputs settle before pipe negedge capture
//  RST          in   1      asynchronous, active-high reset
//  valid_id     in   1      ID stage holds a valid instruction
//  rs_id        in   5      ID source register 1
//  rt_id        in   5      ID source register 2
//  use_rs_id    in   1      ID instruction reads rs
//  use_rt_id    in   1      ID instruction reads rt
//  valid_ex     in   1      EX stage holds a valid instruction
//  rdst_ex      in   5      EX destination register
//  rwren_ex     in   1      EX instruction writes the register file
//  load_ex      in   1      EX instruction is a load
//  redirect_ex  in   1      taken branch or jump resolved in EX (qualified by valid_ex)
//  mem_req      in   1      MEM stage issues a data-memory access
//  mem_ready    in   1      data memory completes the access this cycle
//  halt_wb      in   1      halt instruction present in WB
//  wen_pc       out  1      hold PC
//  wen_if_id    out  1      hold IF/ID
//  wen_id_ex    out  1      hold ID/EX
//  wen_ex_mem   out  1      hold EX/MEM
//  wen_mem_wb   out  1      hold MEM/WB
//  kill_if      out  1      squash the IF-stage instruction (valid_if := 0)
//  kill_id      out  1      squash the ID-stage instruction (bubble into EX)
//  halted       out  1      sticky: pipeline frozen by halt or mem_err
//  mem_err      out  1      sticky: MEM_WAIT exceeded MEM_TIMEOUT
//  stall_cnt    out  CNT_W  cycles with wen_pc=1 while not halted; saturates at all-ones
//  flush_cnt    out  CNT_W  redirect flushes taken; saturates at all-ones
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT, HALTED. Reset value: RUN, all outputs 0, counters 0, wait counter 0.
//  - While RST=1, every hold and kill output is forced to 0.
//  - Priority, high to low: HALTED > memory wait > redirect > load-use.
//  - HALTED: all five wen_* = 1; kills = 0; halted = 1. Left only by RST.
//  - Memory wait:
//    - mw = (RUN & mem_req & !mem_ready) | (MEM_WAIT & !mem_ready).
//    - mw=1 -> all wen_* = 1, kills = 0.
//    - RUN -> MEM_WAIT when mw=1 at posedge.
//    - MEM_WAIT -> RUN in the cycle after mem_ready=1. The pipe advances in the mem_ready cycle itself.
//    - Wait counter: cleared on entry to MEM_WAIT, +1 per MEM_WAIT cycle.
//    - Reaching MEM_TIMEOUT with mem_ready=0 -> mem_err=1, state HALTED.
//    - mem_ready=1 in the same cycle as timeout: the completion wins, no error.
//  - Redirect (RUN, no mw, valid_ex & redirect_ex):
//    - kill_if=1, kill_id=1, no holds.
//    - flush_cnt +1. A redirect coinciding with load-use is counted once and causes no stall.
//  - Load-use (RUN, no mw, no redirect):
//    - Condition: valid_ex & load_ex & rwren_ex & rdst_ex!=0 & valid_id & ((use_rs_id & rs_id==rdst_ex) | (use_rt_id & rt_id==rdst_ex)).
//    - Response: wen_pc=1, wen_if_id=1, kill_id=1. Exactly one cycle; forwarding covers the next cycle.
//  - halt_wb=1 at posedge, from RUN or MEM_WAIT -> HALTED.
//    - Outputs in that same cycle follow the normal rules; the halt itself has already retired.
//  - Counters saturate and never wrap. stall_cnt does not count while RST=1 or in HALTED.
//  - RST during MEM_WAIT: immediate return to RUN; mem_err and the wait counter are cleared.
// TESTING
//  - lw r5 in EX, ID reads rs=5 -> 1 cycle: wen_pc=wen_if_id=kill_id=1; stall_cnt=1.
//  - Same load with rdst_ex=0 -> no stall; all outputs 0.
//  - redirect_ex=1 together with a load-use match -> kill_if=kill_id=1, wen_pc=0; flush_cnt=1.
//  - mem_req=1, mem_ready low 3 cycles then high -> all wen_*=1 for 3 cycles, release in the 4th; stall_cnt=3.
//  - MEM_TIMEOUT=4, mem_ready stuck 0 -> mem_err=1, halted=1 on the 5th posedge; holds stay 1.
//  - halt_wb=1 -> halted=1 next cycle; all wen_*=1 until RST=1; RST mid-MEM_WAIT -> RUN, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and its hazard controller.
// The datapath side is the master; the controller is the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             valid_id;
    logic [4:0]       rs_id;
    logic [4:0]       rt_id;
    logic             use_rs_id;
    logic             use_rt_id;
    logic             valid_ex;
    logic [4:0]       rdst_ex;
    logic             rwren_ex;
    logic             load_ex;
    logic             redirect_ex;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_wb;

    logic             wen_pc;
    logic             wen_if_id;
    logic             wen_id_ex;
    logic             wen_ex_mem;
    logic             wen_mem_wb;
    logic             kill_if;
    logic             kill_id;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output valid_id, rs_id, rt_id, use_rs_id, use_rt_id,
               valid_ex, rdst_ex, rwren_ex, load_ex, redirect_ex,
               mem_req, mem_ready, halt_wb,
        input  wen_pc, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb,
               kill_if, kill_id, halted, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  valid_id, rs_id, rt_id, use_rs_id, use_rt_id,
               valid_ex, rdst_ex, rwren_ex, load_ex, redirect_ex,
               mem_req, mem_ready, halt_wb,
        output wen_pc, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb,
               kill_if, kill_id, halted, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hold/kill control for a 5-stage pipe: load-use stall, redirect flush,
// data-memory wait freeze with timeout, and halt freeze, plus saturating counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_mem_err;

    logic w_run;
    logic w_mw;
    logic w_redirect;
    logic w_src_hit;
    logic w_load_use;
    logic w_hold_all;
    logic w_stall;
    logic w_timeout;

    // NOTE: always_comb with every output assigned on every path keeps this a pure decode, no latches.
    always_comb begin
        w_run      = (r_state == RUN);
        w_mw       = (w_run & bus.mem_req & ~bus.mem_ready) |
                     ((r_state == MEM_WAIT) & ~bus.mem_ready);
        w_redirect = w_run & ~w_mw & bus.valid_ex & bus.redirect_ex;
        w_src_hit  = (bus.use_rs_id & (bus.rs_id == bus.rdst_ex)) |
                     (bus.use_rt_id & (bus.rt_id == bus.rdst_ex));
        w_load_use = w_run & ~w_mw & ~w_redirect &
                     bus.valid_ex & bus.load_ex & bus.rwren_ex & (bus.rdst_ex != 5'd0) &
                     bus.valid_id & w_src_hit;
        w_hold_all = (r_state == HALTED) | w_mw;
        w_stall    = w_hold_all | w_load_use;
        w_timeout  = (r_state == MEM_WAIT) & ~bus.mem_ready & (r_wait_cnt == TIMEOUT_LAST);
    end

    // Holds and kills are decoded from the current cycle so the pipe sees them before its negedge capture.
    assign bus.wen_pc     = ~RST & w_stall;
    assign bus.wen_if_id  = ~RST & w_stall;
    assign bus.wen_id_ex  = ~RST & w_hold_all;
    assign bus.wen_ex_mem = ~RST & w_hold_all;
    assign bus.wen_mem_wb = ~RST & w_hold_all;
    assign bus.kill_if    = ~RST & w_redirect;
    assign bus.kill_id    = ~RST & (w_redirect | w_load_use);
    assign bus.halted     = (r_state == HALTED);
    assign bus.mem_err    = r_mem_err;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            if (w_stall && r_state != HALTED && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;

            case (r_state)
                RUN: begin
                    if (bus.halt_wb) begin
                        r_state <= HALTED;
                    end else if (w_mw) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    // A completion on the timeout cycle beats the error.
                    if (w_timeout) begin
                        r_mem_err <= 1'b1;
                        r_state   <= HALTED;
                    end else if (bus.halt_wb) begin
                        r_state <= HALTED;
                    end else if (bus.mem_ready) begin
                        r_state <= RUN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazards, memory wait/timeout,
// halt freeze, reset behaviour and counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    // {wen_pc, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb, kill_if, kill_id, halted, mem_err}
    localparam logic [8:0] IDLE   = 9'b000000000;
    localparam logic [8:0] LU     = 9'b110000100;
    localparam logic [8:0] RD     = 9'b000001100;
    localparam logic [8:0] MW     = 9'b111110000;
    localparam logic [8:0] HT     = 9'b111110010;
    localparam logic [8:0] HT_ERR = 9'b111110011;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ctl();
        return {bus.wen_pc, bus.wen_if_id, bus.wen_id_ex, bus.wen_ex_mem, bus.wen_mem_wb,
                bus.kill_if, bus.kill_id, bus.halted, bus.mem_err};
    endfunction

    task automatic clear_in();
        bus.valid_id = 0; bus.rs_id = 0; bus.rt_id = 0; bus.use_rs_id = 0; bus.use_rt_id = 0;
        bus.valid_ex = 0; bus.rdst_ex = 0; bus.rwren_ex = 0; bus.load_ex = 0;
        bus.redirect_ex = 0; bus.mem_req = 0; bus.mem_ready = 0; bus.halt_wb = 0;
    endtask

    task automatic set_in(input logic vid, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic vex,
                          input logic [4:0] rd, input logic rw, input logic ld, input logic redir);
        bus.valid_id = vid; bus.rs_id = rs; bus.rt_id = rt; bus.use_rs_id = urs; bus.use_rt_id = urt;
        bus.valid_ex = vex; bus.rdst_ex = rd; bus.rwren_ex = rw; bus.load_ex = ld;
        bus.redirect_ex = redir;
    endtask

    // Inputs are already applied; look at outputs on the negedge, then cross one posedge.
    task automatic cyc(input logic [8:0] exp, input string tag);
        @(negedge CLK);
        check(tag, 32'(ctl()), 32'(exp));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b1;
        clear_in();
        bus.mem_req = 1'b1;
        @(negedge CLK);
        check("rst_force", 32'(ctl()), 32'(IDLE));
        check("rst_stall", 32'(bus.stall_cnt), 0);
        check("rst_flush", 32'(bus.flush_cnt), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        clear_in();
        cyc(IDLE, "idle");

        // Load-use detection and its qualifiers
        set_in(1, 5, 0, 1, 0, 1, 5, 1, 1, 0); cyc(LU, "lu_rs");
        clear_in();
        check("lu_stall1", 32'(bus.stall_cnt), 1);
        set_in(1, 0, 7, 0, 1, 1, 7, 1, 1, 0); cyc(LU, "lu_rt");
        set_in(1, 0, 0, 1, 0, 1, 0, 1, 1, 0); cyc(IDLE, "lu_r0");
        set_in(1, 5, 0, 0, 0, 1, 5, 1, 1, 0); cyc(IDLE, "lu_nouse");
        set_in(0, 5, 0, 1, 0, 1, 5, 1, 1, 0); cyc(IDLE, "lu_id_inv");
        set_in(1, 5, 0, 1, 0, 1, 5, 1, 0, 0); cyc(IDLE, "lu_noload");
        set_in(1, 5, 0, 1, 0, 1, 5, 0, 1, 0); cyc(IDLE, "lu_nowr");
        set_in(1, 5, 0, 1, 0, 0, 5, 1, 1, 0); cyc(IDLE, "lu_ex_inv");
        set_in(1, 5, 6, 1, 1, 1, 4, 1, 1, 0); cyc(IDLE, "lu_nomatch");
        set_in(1, 5, 0, 1, 0, 1, 5, 1, 1, 1); cyc(RD, "redir_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc(IDLE, "redir_ex_inv");
        clear_in();
        check("lu_stall2", 32'(bus.stall_cnt), 2);
        check("flush1", 32'(bus.flush_cnt), 1);

        // Memory wait of 3 cycles; mw outranks a redirect
        bus.mem_req = 1; bus.valid_ex = 1; bus.redirect_ex = 1;
        cyc(MW, "mw_redir");
        bus.valid_ex = 0; bus.redirect_ex = 0;
        cyc(MW, "mw_1");
        cyc(MW, "mw_2");
        bus.mem_ready = 1;
        cyc(IDLE, "mw_release");
        clear_in();
        cyc(IDLE, "mw_back_run");
        check("mw_stall", 32'(bus.stall_cnt), 5);
        check("mw_flush", 32'(bus.flush_cnt), 1);
        bus.mem_req = 1; bus.mem_ready = 1;
        cyc(IDLE, "mem_hit");

        // mem_ready on the timeout cycle wins
        bus.mem_ready = 0;
        repeat (4) cyc(MW, "mw_edge");
        bus.mem_ready = 1;
        cyc(IDLE, "ready_wins");
        clear_in();
        cyc(IDLE, "no_err");
        check("edge_stall", 32'(bus.stall_cnt), 9);

        // Timeout: mem_err and halted after the 5th posedge
        bus.mem_req = 1;
        repeat (5) cyc(MW, "tmo_wait");
        clear_in();
        cyc(HT_ERR, "tmo_halt");
        set_in(1, 5, 0, 1, 0, 1, 5, 1, 1, 1);
        cyc(HT_ERR, "halt_prio");
        check("tmo_stall", 32'(bus.stall_cnt), 14);
        check("tmo_flush", 32'(bus.flush_cnt), 1);

        // Reset out of HALTED
        RST = 1'b1; #1;
        check("rst_halt_ctl", 32'(ctl()), 32'(IDLE));
        check("rst_halt_stall", 32'(bus.stall_cnt), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        clear_in();

        // Reset in the middle of MEM_WAIT
        bus.mem_req = 1;
        cyc(MW, "mw_pre_rst0");
        cyc(MW, "mw_pre_rst1");
        check("mw_pre_rst_stall", 32'(bus.stall_cnt), 2);
        RST = 1'b1; #1;
        check("rst_mw_force", 32'(ctl()), 32'(IDLE));
        check("rst_mw_stall", 32'(bus.stall_cnt), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        clear_in();
        cyc(IDLE, "rst_mw_run");

        // Halt retiring: same-cycle outputs follow normal rules, then freeze
        set_in(1, 5, 0, 1, 0, 1, 5, 1, 1, 0);
        bus.halt_wb = 1;
        cyc(LU, "halt_same");
        clear_in();
        cyc(HT, "halted");
        cyc(HT, "halted_hold");
        check("halt_stall", 32'(bus.stall_cnt), 1);

        // Counter saturation at 4'hF
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        set_in(1, 5, 0, 1, 0, 1, 5, 1, 1, 0);
        repeat (20) cyc(LU, "sat_lu");
        check("stall_sat", 32'(bus.stall_cnt), 15);
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        repeat (18) cyc(RD, "sat_rd");
        check("flush_sat", 32'(bus.flush_cnt), 15);
        check("stall_sat_hold", 32'(bus.stall_cnt), 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
